// File: rtl/uart_bus_ctrl.sv
// uart_bus_ctrl: bus master that drives the cpu_if C_nD/n_RD/n_WR/n_CS port.
// It writes the config register, polls status and moves received bytes into
// a one-entry holding register. Host bytes go to the Tx FIFO. When Rx and Tx
// service are both eligible, the one not served last wins.
//
// Handshakes: a byte moves on tx_* in the cycle tx_valid & tx_ready, and on
// rx_* in the cycle rx_valid & rx_ready. tx_ready is a single-cycle grant
// issued only when tx_valid is high. rx_valid stays high until consumed.
module uart_bus_ctrl #(
    parameter int STROBE_CYCLES = 2,
    parameter int POLL_GAP      = 4
) (
    input  logic       CLK50MHZ,
    input  logic       RST,
    input  logic [7:0] cfg_word,
    input  logic       cfg_load,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic [2:0] err_flags,
    output logic       configured,
    output logic       busy,
    output logic       C_nD,
    output logic       n_RD,
    output logic       n_WR,
    output logic       n_CS,
    output logic [7:0] BUS_WDATA,
    input  logic [7:0] BUS_RDATA
);

    localparam int CW = 16;
    localparam logic [CW-1:0] GAP_LAST  = CW'(POLL_GAP - 1);
    localparam logic [CW-1:0] STRB_LAST = CW'(STROBE_CYCLES - 1);

    typedef enum logic [2:0] {
        S_GAP,
        S_ARB,
        S_SETUP,
        S_STROBE,
        S_RECOV,
        S_DECIDE
    } state_t;

    typedef enum logic [1:0] {
        K_CFG,
        K_STAT,
        K_RX,
        K_TX
    } kind_t;

    state_t          state, state_d;
    kind_t           kind, kind_d;
    logic [CW-1:0]   gap_cnt;
    logic [CW-1:0]   strb_cnt;
    logic [7:0]      cfg_byte;
    logic            cfg_pending;
    logic            last_rx;
    logic [7:0]      rd_q;
    logic            rx_elig;
    logic            tx_elig;
    logic            pick_rx;
    logic            pick_tx;
    logic            in_acc;
    logic            cfg_done;
    logic            stat_done;
    logic            rx_done;

    // Eligibility is judged on the status byte sampled during the last poll.
    assign rx_elig   = rd_q[0] & ~rx_valid;
    assign tx_elig   = rd_q[1] & tx_valid;
    assign pick_rx   = rx_elig & (~tx_elig | ~last_rx);
    assign pick_tx   = tx_elig & ~pick_rx;
    assign cfg_done  = (state == S_RECOV) && (kind == K_CFG);
    assign stat_done = (state == S_RECOV) && (kind == K_STAT);
    assign rx_done   = (state == S_RECOV) && (kind == K_RX);

    // State, access kind and the gap/strobe cycle counters.
    always_ff @(posedge CLK50MHZ or posedge RST) begin
        if (RST) begin
            state    <= S_GAP;
            kind     <= K_CFG;
            gap_cnt  <= '0;
            strb_cnt <= '0;
        end else begin
            state <= state_d;
            kind  <= kind_d;
            if (state == S_GAP && gap_cnt != GAP_LAST) begin
                gap_cnt <= gap_cnt + CW'(1);
            end else begin
                gap_cnt <= '0;
            end
            if (state == S_STROBE && strb_cnt != STRB_LAST) begin
                strb_cnt <= strb_cnt + CW'(1);
            end else begin
                strb_cnt <= '0;
            end
        end
    end

    // Next-state selection and bus strobes decoded from the current state.
    always_comb begin
        state_d  = state;
        kind_d   = kind;
        in_acc   = 1'b0;
        busy     = 1'b0;
        n_CS     = 1'b1;
        C_nD     = 1'b0;
        n_RD     = 1'b1;
        n_WR     = 1'b1;
        tx_ready = 1'b0;
        case (state)
            S_GAP: begin
                if (gap_cnt == GAP_LAST) state_d = S_ARB;
            end
            S_ARB: begin
                if (cfg_pending) begin
                    state_d = S_SETUP;
                    kind_d  = K_CFG;
                end else if (configured) begin
                    state_d = S_SETUP;
                    kind_d  = K_STAT;
                end else begin
                    state_d = S_GAP;
                end
            end
            S_SETUP: begin
                in_acc  = 1'b1;
                state_d = S_STROBE;
            end
            S_STROBE: begin
                in_acc = 1'b1;
                if (kind == K_STAT || kind == K_RX) n_RD = 1'b0;
                else                                n_WR = 1'b0;
                if (strb_cnt == STRB_LAST) state_d = S_RECOV;
            end
            S_RECOV: begin
                in_acc  = 1'b1;
                state_d = (kind == K_STAT) ? S_DECIDE : S_GAP;
            end
            S_DECIDE: begin
                tx_ready = pick_tx;
                if (pick_rx) begin
                    state_d = S_SETUP;
                    kind_d  = K_RX;
                end else if (pick_tx) begin
                    state_d = S_SETUP;
                    kind_d  = K_TX;
                end else begin
                    state_d = S_GAP;
                end
            end
            default: state_d = S_GAP;
        endcase
        if (in_acc) begin
            busy = 1'b1;
            n_CS = 1'b0;
            C_nD = (kind == K_CFG) || (kind == K_STAT);
        end
    end

    // Write data latch and read sampling on the last strobe cycle.
    always_ff @(posedge CLK50MHZ or posedge RST) begin
        if (RST) begin
            BUS_WDATA <= '0;
            rd_q      <= '0;
        end else begin
            if (state == S_ARB && cfg_pending) BUS_WDATA <= cfg_byte;
            else if (state == S_DECIDE && pick_tx) BUS_WDATA <= tx_data;
            if (state == S_STROBE && strb_cnt == STRB_LAST) rd_q <= BUS_RDATA;
        end
    end

    // Config capture; a new cfg_load always wins over completion of the old one.
    always_ff @(posedge CLK50MHZ or posedge RST) begin
        if (RST) begin
            cfg_byte    <= '0;
            cfg_pending <= 1'b0;
            configured  <= 1'b0;
        end else begin
            if (cfg_load) begin
                cfg_byte    <= cfg_word;
                cfg_pending <= 1'b1;
            end else if (cfg_done) begin
                cfg_pending <= 1'b0;
            end
            if (cfg_done) configured <= 1'b1;
        end
    end

    // Sticky error flags {OE, FE, PE}, cleared by cfg_load or an I_Rst write.
    always_ff @(posedge CLK50MHZ or posedge RST) begin
        if (RST) begin
            err_flags <= '0;
        end else if (cfg_load || (cfg_done && BUS_WDATA[7])) begin
            err_flags <= '0;
        end else if (stat_done) begin
            err_flags <= err_flags | {rd_q[4], rd_q[3], rd_q[2]};
        end
    end

    // Rx holding register and round-robin memory of the last serviced side.
    always_ff @(posedge CLK50MHZ or posedge RST) begin
        if (RST) begin
            rx_data  <= '0;
            rx_valid <= 1'b0;
            last_rx  <= 1'b0;
        end else begin
            if (cfg_done && BUS_WDATA[7]) begin
                rx_valid <= 1'b0;
            end else if (rx_done) begin
                rx_data  <= rd_q;
                rx_valid <= 1'b1;
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
            if (state == S_DECIDE) begin
                if (pick_rx)      last_rx <= 1'b1;
                else if (pick_tx) last_rx <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_bus_ctrl.sv
// Bench for uart_bus_ctrl: a bus responder feeds status/Rx bytes, a monitor
// turns bus activity into access records, and a transaction-level model
// predicts which access should follow each status poll.
module tb_uart_bus_ctrl;

  localparam int STROBE_CYCLES = 2;
  localparam int POLL_GAP      = 4;
  localparam int ACC_LEN       = STROBE_CYCLES + 2;
  localparam int POLL_PERIOD   = POLL_GAP + 1 + ACC_LEN + 1;
  localparam int K_CFG  = 0;
  localparam int K_STAT = 1;
  localparam int K_RX   = 2;
  localparam int K_TX   = 3;
  localparam int K_NONE = 4;
  localparam logic [26:0] RST_VEC = {3'b111, 24'h0};

  typedef struct {
    int         kind;
    logic [7:0] wdata;
    int         strobe_len;
    int         cs_len;
    int         start_cyc;
    bit         stable;
  } acc_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] cfg_word;
  logic       cfg_load;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic [2:0] err_flags;
  logic       configured;
  logic       busy;
  logic       c_nd;
  logic       n_rd;
  logic       n_wr;
  logic       n_cs;
  logic [7:0] bus_wdata;
  logic [7:0] bus_rdata;

  logic [7:0] status_val;
  logic [7:0] rx_byte;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int overlap_cnt = 0;
  int busy_err = 0;
  int tx_pulse_cnt = 0;
  acc_t obs_q[$];
  logic [9:0] exp_q[$];

  // Model state
  bit       m_holding = 0;
  bit       m_last_rx = 0;
  logic [2:0] m_err = 3'b000;

  // Monitor state
  bit         mon_in_acc = 0;
  acc_t       mon_cur;
  logic       mon_cnd;
  bit         mon_wr;

  uart_bus_ctrl #(
    .STROBE_CYCLES(STROBE_CYCLES),
    .POLL_GAP(POLL_GAP)
  ) dut (
    .CLK50MHZ  (clk),
    .RST       (rst),
    .cfg_word  (cfg_word),
    .cfg_load  (cfg_load),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .err_flags (err_flags),
    .configured(configured),
    .busy      (busy),
    .C_nD      (c_nd),
    .n_RD      (n_rd),
    .n_WR      (n_wr),
    .n_CS      (n_cs),
    .BUS_WDATA (bus_wdata),
    .BUS_RDATA (bus_rdata)
  );

  // Clock and cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // UART register file responder: status on control reads, Rx byte on data reads
  assign bus_rdata = c_nd ? status_val : rx_byte;

  // Bus monitor: one record per n_CS-low window
  initial begin
    forever begin
      @(negedge clk);
      if (tx_ready === 1'b1) tx_pulse_cnt++;
      if (n_rd === 1'b0 && n_wr === 1'b0) overlap_cnt++;
      if (busy !== ~n_cs) busy_err++;
      if (rst) begin
        mon_in_acc = 0;
      end else if (n_cs === 1'b0) begin
        if (!mon_in_acc) begin
          mon_in_acc = 1;
          mon_cur.start_cyc = cyc;
          mon_cur.wdata = bus_wdata;
          mon_cur.strobe_len = 0;
          mon_cur.cs_len = 0;
          mon_cur.stable = 1;
          mon_cnd = c_nd;
          mon_wr = 0;
        end
        mon_cur.cs_len++;
        if (c_nd !== mon_cnd || bus_wdata !== mon_cur.wdata) mon_cur.stable = 0;
        if (n_rd === 1'b0 || n_wr === 1'b0) mon_cur.strobe_len++;
        if (n_wr === 1'b0) mon_wr = 1;
      end else if (mon_in_acc) begin
        mon_in_acc = 0;
        mon_cur.kind = mon_cnd ? (mon_wr ? K_CFG : K_STAT) : (mon_wr ? K_TX : K_RX);
        obs_q.push_back(mon_cur);
      end
    end
  end

  // Driver: wait (bounded) for the next completed bus access record
  task automatic wait_access(output acc_t r, output bit ok);
    int n = 0;
    r.kind = -1;
    r.wdata = 8'h00;
    r.strobe_len = -1;
    r.cs_len = -1;
    r.start_cyc = 0;
    r.stable = 0;
    ok = 0;
    while (obs_q.size() == 0 && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (obs_q.size() > 0) begin
      r = obs_q.pop_front();
      ok = 1;
    end
  endtask

  // Driver: single-cycle rx_ready pulse
  task automatic pulse_rx_ready;
    rx_ready = 1'b1;
    @(negedge clk);
    #1;
    rx_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    cfg_word = 8'h00; cfg_load = 1'b0; tx_data = 8'h00; tx_valid = 1'b0;
    rx_ready = 1'b0; status_val = 8'h00; rx_byte = 8'h00;
    repeat (3) @(negedge clk);
    #1;
    total++;
    if ({n_cs, n_rd, n_wr, c_nd, busy, tx_ready, rx_valid, configured, err_flags, bus_wdata, rx_data} !== RST_VEC)
      begin bad++; $display("FAIL reset_outputs: got %h want %h",
        {n_cs, n_rd, n_wr, c_nd, busy, tx_ready, rx_valid, configured, err_flags, bus_wdata, rx_data}, RST_VEC); end
    @(negedge clk);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    #1;
    total++;
    if (obs_q.size() != 0 || configured !== 1'b0) begin
      bad++; $display("FAIL unconfigured_idle: accesses=%0d configured=%b want 0/0", obs_q.size(), configured);
    end
  endtask

  task automatic test_config;
    acc_t r, p1, p2;
    bit ok, ok1, ok2;
    cfg_word = 8'h2F;
    cfg_load = 1'b1;
    @(negedge clk);
    #1;
    cfg_load = 1'b0;
    wait_access(r, ok);
    total++;
    if (!ok || r.kind != K_CFG || r.wdata !== 8'h2F) begin
      bad++; $display("FAIL cfg_write: ok=%b kind=%0d data=%h want kind=%0d data=2f", ok, r.kind, r.wdata, K_CFG);
    end
    total++;
    if (r.strobe_len != STROBE_CYCLES || r.cs_len != ACC_LEN || !r.stable) begin
      bad++; $display("FAIL cfg_timing: strobe=%0d cs=%0d stable=%b want %0d %0d 1",
        r.strobe_len, r.cs_len, r.stable, STROBE_CYCLES, ACC_LEN);
    end
    total++;
    if (configured !== 1'b1) begin bad++; $display("FAIL configured: got %b want 1", configured); end
    wait_access(p1, ok1);
    wait_access(p2, ok2);
    total++;
    if (!ok1 || !ok2 || p1.kind != K_STAT || p2.kind != K_STAT || (p2.start_cyc - p1.start_cyc) != POLL_PERIOD) begin
      bad++; $display("FAIL poll_period: kinds=%0d,%0d period=%0d want %0d", p1.kind, p2.kind,
        p2.start_cyc - p1.start_cyc, POLL_PERIOD);
    end
  endtask

  task automatic test_rx;
    acc_t r;
    bit ok;
    @(negedge clk);
    #1;
    status_val = 8'h01; rx_byte = 8'h89; rx_ready = 1'b0;
    wait_access(r, ok);
    total++;
    if (!ok || r.kind != K_STAT || tx_ready !== 1'b0) begin
      bad++; $display("FAIL rx_poll: kind=%0d tx_ready=%b want %0d 0", r.kind, tx_ready, K_STAT);
    end
    wait_access(r, ok);
    total++;
    if (!ok || r.kind != K_RX || r.strobe_len != STROBE_CYCLES || r.cs_len != ACC_LEN) begin
      bad++; $display("FAIL rx_read: kind=%0d strobe=%0d cs=%0d want %0d %0d %0d", r.kind, r.strobe_len, r.cs_len,
        K_RX, STROBE_CYCLES, ACC_LEN);
    end
    total++;
    if (rx_valid !== 1'b1 || rx_data !== 8'h89) begin
      bad++; $display("FAIL rx_data: valid=%b data=%h want 1 89", rx_valid, rx_data);
    end
    m_holding = 1; m_last_rx = 1;
    rx_byte = 8'h55;
    for (int i = 0; i < 2; i++) begin
      wait_access(r, ok);
      total++;
      if (!ok || r.kind != K_STAT) begin
        bad++; $display("FAIL rx_hold_block: poll %0d kind=%0d want %0d", i, r.kind, K_STAT);
      end
    end
    total++;
    if (rx_valid !== 1'b1 || rx_data !== 8'h89) begin
      bad++; $display("FAIL rx_hold: valid=%b data=%h want 1 89", rx_valid, rx_data);
    end
    pulse_rx_ready();
    m_holding = 0;
    status_val = 8'h00;
    total++;
    if (rx_valid !== 1'b0) begin bad++; $display("FAIL rx_consume: valid=%b want 0", rx_valid); end
  endtask

  task automatic test_tx;
    acc_t r;
    bit ok;
    int p0;
    status_val = 8'h02; tx_valid = 1'b1; tx_data = 8'hDA;
    p0 = tx_pulse_cnt;
    wait_access(r, ok);
    total++;
    if (!ok || r.kind != K_STAT || tx_ready !== 1'b1) begin
      bad++; $display("FAIL tx_grant: kind=%0d tx_ready=%b want %0d 1", r.kind, tx_ready, K_STAT);
    end
    @(negedge clk);
    #1;
    tx_valid = 1'b0;
    tx_data = 8'h00;
    wait_access(r, ok);
    total++;
    if (!ok || r.kind != K_TX || r.wdata !== 8'hDA || r.strobe_len != STROBE_CYCLES || !r.stable) begin
      bad++; $display("FAIL tx_write: kind=%0d data=%h strobe=%0d stable=%b want %0d da %0d 1",
        r.kind, r.wdata, r.strobe_len, r.stable, K_TX, STROBE_CYCLES);
    end
    total++;
    if (tx_pulse_cnt - p0 != 1) begin
      bad++; $display("FAIL tx_pulse_count: got %0d want 1", tx_pulse_cnt - p0);
    end
    m_last_rx = 0;
    status_val = 8'h00;
  endtask

  task automatic test_alternate;
    acc_t r;
    bit ok;
    bit exp_rx;
    status_val = 8'h03; tx_valid = 1'b1;
    tx_data = 8'($urandom); rx_byte = 8'($urandom);
    for (int i = 0; i < 4; i++) begin
      exp_rx = !m_last_rx;
      wait_access(r, ok);
      total++;
      if (!ok || r.kind != K_STAT || tx_ready !== !exp_rx) begin
        bad++; $display("FAIL alt_decide %0d: kind=%0d tx_ready=%b want %0d %b", i, r.kind, tx_ready, K_STAT, !exp_rx);
      end
      wait_access(r, ok);
      total++;
      if (!ok || r.kind != (exp_rx ? K_RX : K_TX) || (!exp_rx && r.wdata !== tx_data)) begin
        bad++; $display("FAIL alt_access %0d: kind=%0d data=%h want %0d %h", i, r.kind, r.wdata,
          exp_rx ? K_RX : K_TX, tx_data);
      end
      if (exp_rx) begin
        total++;
        if (rx_valid !== 1'b1 || rx_data !== rx_byte) begin
          bad++; $display("FAIL alt_rx_data %0d: valid=%b data=%h want 1 %h", i, rx_valid, rx_data, rx_byte);
        end
        pulse_rx_ready();
      end
      m_last_rx = exp_rx;
      tx_data = 8'($urandom);
      rx_byte = 8'($urandom);
    end
    status_val = 8'h00;
    tx_valid = 1'b0;
  endtask

  task automatic test_err;
    acc_t r;
    bit ok;
    status_val = 8'h15; rx_byte = 8'h3C; tx_valid = 1'b0;
    wait_access(r, ok);
    m_err = m_err | {status_val[4], status_val[3], status_val[2]};
    total++;
    if (!ok || r.kind != K_STAT || err_flags !== m_err) begin
      bad++; $display("FAIL err_sticky: kind=%0d err=%b want %0d %b", r.kind, err_flags, K_STAT, m_err);
    end
    wait_access(r, ok);
    total++;
    if (!ok || r.kind != K_RX || rx_valid !== 1'b1 || rx_data !== 8'h3C) begin
      bad++; $display("FAIL err_rx_read: kind=%0d valid=%b data=%h want %0d 1 3c", r.kind, rx_valid, rx_data, K_RX);
    end
    m_holding = 1; m_last_rx = 1;
    status_val = 8'h00;
    cfg_word = 8'hAF;
    cfg_load = 1'b1;
    @(negedge clk);
    #1;
    cfg_load = 1'b0;
    m_err = 3'b000;
    total++;
    if (err_flags !== m_err || rx_valid !== 1'b1) begin
      bad++; $display("FAIL cfg_load_clear: err=%b valid=%b want 000 1", err_flags, rx_valid);
    end
    wait_access(r, ok);
    total++;
    if (!ok || r.kind != K_CFG || r.wdata !== 8'hAF) begin
      bad++; $display("FAIL irst_write: kind=%0d data=%h want %0d af", r.kind, r.wdata, K_CFG);
    end
    m_holding = 0;
    total++;
    if (rx_valid !== 1'b0 || err_flags !== 3'b000 || configured !== 1'b1) begin
      bad++; $display("FAIL irst_effect: valid=%b err=%b cfgd=%b want 0 000 1", rx_valid, err_flags, configured);
    end
  endtask

  task automatic test_random;
    acc_t r;
    bit ok;
    bit rx_e, tx_e;
    int exp_kind;
    logic [9:0] e;
    for (int it = 0; it < 40; it++) begin
      if (m_holding && $urandom_range(0, 1) == 1) begin
        pulse_rx_ready();
        m_holding = 0;
      end
      status_val = 8'($urandom);
      if ($urandom_range(0, 3) != 0) status_val[4:2] = 3'b000;
      tx_valid = 1'($urandom_range(0, 1));
      tx_data = 8'($urandom);
      rx_byte = 8'($urandom);
      wait_access(r, ok);
      m_err = m_err | {status_val[4], status_val[3], status_val[2]};
      total++;
      if (!ok || r.kind != K_STAT || err_flags !== m_err) begin
        bad++; $display("FAIL rnd_poll %0d: kind=%0d err=%b want %0d %b", it, r.kind, err_flags, K_STAT, m_err);
      end
      rx_e = status_val[0] && !m_holding;
      tx_e = status_val[1] && tx_valid;
      if (rx_e && (!tx_e || !m_last_rx)) exp_kind = K_RX;
      else if (tx_e) exp_kind = K_TX;
      else exp_kind = K_NONE;
      total++;
      if (tx_ready !== (exp_kind == K_TX)) begin
        bad++; $display("FAIL rnd_tx_ready %0d: got %b want %b", it, tx_ready, exp_kind == K_TX);
      end
      if (exp_kind == K_NONE) begin
        @(negedge clk);
        #1;
      end else begin
        exp_q.push_back({2'(exp_kind), (exp_kind == K_TX) ? tx_data : rx_byte});
        wait_access(r, ok);
        e = exp_q.pop_front();
        total++;
        if (!ok || r.kind != int'(e[9:8]) || (e[9:8] == 2'(K_TX) && r.wdata !== e[7:0]) ||
            (e[9:8] == 2'(K_RX) && (rx_valid !== 1'b1 || rx_data !== e[7:0]))) begin
          bad++; $display("FAIL rnd_access %0d: kind=%0d wdata=%h rx=%b/%h want kind=%0d byte=%h",
            it, r.kind, r.wdata, rx_valid, rx_data, e[9:8], e[7:0]);
        end
        if (exp_kind == K_RX) begin
          m_holding = 1; m_last_rx = 1;
        end else begin
          m_last_rx = 0;
        end
      end
    end
    tx_valid = 1'b0;
    status_val = 8'h00;
  endtask

  task automatic test_reset_mid;
    bit found = 0;
    status_val = 8'h02; tx_valid = 1'b1; tx_data = 8'h66;
    for (int n = 0; n < 100 && !found; n++) begin
      @(negedge clk);
      #1;
      if (n_wr === 1'b0 && c_nd === 1'b0) found = 1;
    end
    total++;
    if (!found) begin bad++; $display("FAIL reset_mid_reach: no Tx strobe seen, want one"); end
    if (found) begin
      rst = 1'b1;
      #1;
      total++;
      if ({n_cs, n_rd, n_wr, c_nd, busy, tx_ready, rx_valid, configured, err_flags, bus_wdata, rx_data} !== RST_VEC)
        begin bad++; $display("FAIL reset_mid_async: got %h want %h",
          {n_cs, n_rd, n_wr, c_nd, busy, tx_ready, rx_valid, configured, err_flags, bus_wdata, rx_data}, RST_VEC); end
      repeat (2) @(negedge clk);
      #1;
      total++;
      if ({n_cs, n_rd, n_wr, c_nd, busy, tx_ready, rx_valid, configured, err_flags, bus_wdata, rx_data} !== RST_VEC)
        begin bad++; $display("FAIL reset_mid_hold: got %h want %h",
          {n_cs, n_rd, n_wr, c_nd, busy, tx_ready, rx_valid, configured, err_flags, bus_wdata, rx_data}, RST_VEC); end
    end
    tx_valid = 1'b0;
    rst = 1'b0;
  endtask

  // Watchdog: never let the run hang
  initial begin
    #2000000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  // Test sequence and final report
  initial begin
    test_reset();
    test_config();
    test_rx();
    test_tx();
    test_alternate();
    test_err();
    test_random();
    test_reset_mid();
    total++;
    if (overlap_cnt != 0) begin bad++; $display("FAIL strobe_overlap: got %0d cycles want 0", overlap_cnt); end
    total++;
    if (busy_err != 0) begin bad++; $display("FAIL busy_window: got %0d bad cycles want 0", busy_err); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
